timer_unit: RTL and testbench
=============================

Name: timer_unit

Overview:
- Memory-mapped machine timer that generates the `timer_interrupt` level consumed by the processor's CSR/trap logic.
- It sits upstream of the core on the data-memory bus and decodes its own address window.
- It holds a 64-bit `mtime` counter, advanced by a programmable prescaler, and a 64-bit `mtimecmp` compare register.
- The interrupt is asserted while the timer is enabled and `mtime >= mtimecmp`.

Parameters:
- BASE_ADDR, 32'h0000_4000, base of the 32-byte register window; must be 32-byte aligned.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  32  byte address from the ALU result.
- wdata  input  32  store data (rs2 value).
- wr_en  input  1  store strobe, one cycle per write.
- rd_en  input  1  load strobe.
- rdata  output  32  load data, combinational.
- timer_interrupt  output  1  registered level interrupt to the core.

Behaviour:
- Address select: `sel = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00)`.
  - Accesses with `sel` low are ignored.
  - Only word accesses are supported.
- Register offsets (`addr[4:0]`):
  - 0x00 MTIME_LO: `mtime[31:0]`, RW.
  - 0x04 MTIME_HI: `mtime[63:32]`, RW.
  - 0x08 CMP_LO: `mtimecmp[31:0]`, RW.
  - 0x0C CMP_HI: `mtimecmp[63:32]`, RW.
  - 0x10 CTRL: bit0 = EN, bits[15:8] = PRESC; other bits read 0 and ignore writes.
  - 0x14–0x1C: reserved; reads return 0, writes are ignored.
- Read path:
  - `rdata` = selected register when `rd_en && sel`, otherwise 32'h0.
  - Zero latency: same-cycle combinational read of the current register value.
  - If `rd_en` and `wr_en` are both high, the read returns the pre-write value.
- Write path: the register is updated at the rising edge where `wr_en && sel`. A write to one half leaves the other half unchanged.
- Prescaler:
  - 8-bit `presc_cnt`.
  - When EN=1: if `presc_cnt == PRESC`, a tick occurs and `presc_cnt` returns to 0; otherwise `presc_cnt` increments by 1.
  - `mtime` therefore advances by 1 every PRESC+1 cycles. PRESC=0 gives a tick every cycle.
  - When EN=0: `presc_cnt` is held at 0 and `mtime` holds.
  - Any write to CTRL forces `presc_cnt` to 0 on that edge. No tick occurs on that edge.
- `mtime` update priority, evaluated per edge:
  1. rst
  2. write to MTIME_LO or MTIME_HI: the written half takes `wdata`, the other half holds, and no increment occurs on that edge.
  3. tick: `mtime <= mtime + 1` as a full 64-bit add. The carry propagates lo→hi, and 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Interrupt:
  - Every edge: `timer_interrupt <= EN && (mtime >= mtimecmp)`, unsigned 64-bit compare on current register values.
  - One-cycle latency from a register change to the output.
  - Level-sensitive. It is cleared only by raising `mtimecmp`, lowering `mtime`, or clearing EN. There is no sticky pending bit.
- Reset: `mtime` = 0, `mtimecmp` = CMP_RESET, EN = 0, PRESC = 0, `presc_cnt` = 0, `timer_interrupt` = 0. `rdata` is 0 because its inputs are combinational.
- Reset mid-operation: all of the above are restored on the edge where rst is sampled high. An in-flight write on that edge is discarded.
- Non-atomic 64-bit update is a software concern. Writes are accepted in any order; the compare uses whatever values are currently held.

Test Plan:
- Reset, then read all five registers → MTIME 0/0, CMP_LO/HI = 32'hFFFF_FFFF, CTRL 0; `timer_interrupt` = 0; `mtime` still 0 after 20 idle cycles.
- CMP_LO=5, CMP_HI=0, CTRL=32'h1 (PRESC 0) → `mtime` counts 1 per cycle; `timer_interrupt` rises exactly one cycle after `mtime` reads 5; writing CMP_LO=100 drops it one cycle after the write edge.
- CTRL=32'h0000_0301 (PRESC 3) → `mtime` increments every 4 cycles; 40 cycles after enable, `mtime` = 10.
- Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=32'hFFFF_FFFF, EN=1, PRESC=0, CMP=max → next tick gives `mtime` = 0 (wrap); HI reads 0.
- Write MTIME_LO=32'h10 on an edge that is also a tick → `mtime` = 32'h10 after that edge, not 32'h11; the next tick gives 32'h11.
- Accesses to addr BASE+0x02, BASE+0x18, and BASE+0x20 → no register changes, `rdata` = 0; rst asserted with `timer_interrupt` high → 0 on the next edge and registers at reset values.

Source files
------------

// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
//
// Memory-mapped machine timer. It holds a 64-bit mtime counter, advanced by a
// programmable prescaler, and a 64-bit mtimecmp compare register. It raises a
// registered level interrupt while the timer is enabled and mtime >= mtimecmp.
// The unit decodes its own 32-byte word-addressed window on the data bus.
//
// Register window (byte offsets from BASE_ADDR):
//   0x00 MTIME_LO  mtime[31:0]             RW
//   0x04 MTIME_HI  mtime[63:32]            RW
//   0x08 CMP_LO    mtimecmp[31:0]          RW
//   0x0C CMP_HI    mtimecmp[63:32]         RW
//   0x10 CTRL      bit0 = EN, [15:8] = PRESC; all other bits read as 0
//   0x14-0x1C      reserved, read 0, writes ignored
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   rst              synchronous active-high reset
//   addr             byte address of the access
//   wdata            store data
//   wr_en            store strobe, one cycle per write
//   rd_en            load strobe
//   rdata            combinational load data, 0 when not selected
//   timer_interrupt  registered level interrupt to the core
// -----------------------------------------------------------------------------
module timer_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        timer_interrupt
);

    localparam logic [2:0] WORD_MTIME_LO = 3'd0;
    localparam logic [2:0] WORD_MTIME_HI = 3'd1;
    localparam logic [2:0] WORD_CMP_LO   = 3'd2;
    localparam logic [2:0] WORD_CMP_HI   = 3'd3;
    localparam logic [2:0] WORD_CTRL     = 3'd4;

    logic        sel;
    logic [2:0]  word;
    logic        wr_sel;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        tick;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        en;
    logic [7:0]  presc;
    logic [7:0]  presc_cnt;

    // CTRL only implements EN and PRESC; the remaining store bits are dropped.
    logic        unused_wdata;
    assign unused_wdata = ^{wdata[31:16], wdata[7:1]};

    // Only aligned word accesses inside our 32-byte window are honoured.
    assign sel    = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
    assign word   = addr[4:2];
    assign wr_sel = wr_en && sel;

    assign wr_mtime_lo = wr_sel && (word == WORD_MTIME_LO);
    assign wr_mtime_hi = wr_sel && (word == WORD_MTIME_HI);
    assign wr_cmp_lo   = wr_sel && (word == WORD_CMP_LO);
    assign wr_cmp_hi   = wr_sel && (word == WORD_CMP_HI);
    assign wr_ctrl     = wr_sel && (word == WORD_CTRL);

    // A CTRL write restarts the prescale period, so it suppresses the tick
    // that would otherwise fall on the same edge.
    assign tick = en && !wr_ctrl && (presc_cnt == presc);

    // Prescaler: counts 0..PRESC while enabled, held at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= 8'd0;
        end else if (wr_ctrl || !en || (presc_cnt == presc)) begin
            presc_cnt <= 8'd0;
        end else begin
            presc_cnt <= presc_cnt + 8'd1;
        end
    end

    // Control register.
    always_ff @(posedge clk) begin
        if (rst) begin
            en    <= 1'b0;
            presc <= 8'd0;
        end else if (wr_ctrl) begin
            en    <= wdata[0];
            presc <= wdata[15:8];
        end
    end

    // mtime: a software write to either half wins over the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= wdata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Compare register, written one half at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= CMP_RESET;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= wdata;
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= wdata;
        end
    end

    // Level interrupt from the values held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= en && (mtime >= mtimecmp);
        end
    end

    // Zero-latency read of the current register contents.
    always_comb begin
        rdata = 32'h0;
        if (rd_en && sel) begin
            case (word)
                WORD_MTIME_LO: rdata = mtime[31:0];
                WORD_MTIME_HI: rdata = mtime[63:32];
                WORD_CMP_LO:   rdata = mtimecmp[31:0];
                WORD_CMP_HI:   rdata = mtimecmp[63:32];
                WORD_CTRL:     rdata = {16'h0, presc, 7'h0, en};
                default:       rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
//
// Self-checking bench for timer_unit. A behavioural model tracks the timer in
// plain arithmetic (enabled-cycle phase modulo PRESC+1 for ticks, 64-bit
// integer for mtime) and a compare process checks rdata and timer_interrupt
// against it every cycle. Directed sequences add hand-computed literal checks.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
// -----------------------------------------------------------------------------
module tb_timer_unit;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        timer_interrupt;

    int checks = 0;
    int passes = 0;

    timer_unit #(
        .BASE_ADDR(BASE),
        .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wdata(wdata),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .rdata(rdata),
        .timer_interrupt(timer_interrupt)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [63:0] m_time  = 64'd0;
    logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_en    = 1'b0;
    int          m_presc = 0;
    int          m_phase = 0;
    logic        m_irq   = 1'b0;
    logic        m_tick;

    function automatic logic hits(input logic [31:0] a, input int off);
        logic [4:0] o;
        o = off[4:0];
        return (a[31:5] == BASE[31:5]) && (a[4:0] == o);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic re);
        logic [7:0] p;
        p = m_presc[7:0];
        if (!re)        return 32'h0;
        if (hits(a, 0))  return m_time[31:0];
        if (hits(a, 4))  return m_time[63:32];
        if (hits(a, 8))  return m_cmp[31:0];
        if (hits(a, 12)) return m_cmp[63:32];
        if (hits(a, 16)) return {16'h0, p, 7'h0, m_en};
        return 32'h0;
    endfunction

    // Model advance: a tick happens every PRESC+1 enabled cycles counted
    // from the last CTRL write; software writes to mtime beat the tick.
    always @(posedge clk) begin
        if (rst) begin
            m_time  = 64'd0;
            m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_en    = 1'b0;
            m_presc = 0;
            m_phase = 0;
            m_irq   = 1'b0;
        end else begin
            m_irq  = m_en && (m_time >= m_cmp);
            m_tick = 1'b0;
            if (wr_en && hits(addr, 16)) begin
                m_en    = wdata[0];
                m_presc = int'(wdata[15:8]);
                m_phase = 0;
            end else if (m_en) begin
                m_phase = m_phase + 1;
                m_tick  = ((m_phase % (m_presc + 1)) == 0);
            end
            if (wr_en && hits(addr, 0))       m_time[31:0]  = wdata;
            else if (wr_en && hits(addr, 4))  m_time[63:32] = wdata;
            else if (m_tick)                  m_time        = m_time + 64'd1;
            if (wr_en && hits(addr, 8))       m_cmp[31:0]   = wdata;
            else if (wr_en && hits(addr, 12)) m_cmp[63:32]  = wdata;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act === exp) begin
            passes = passes + 1;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        #2;
        check_output("model_irq", {63'h0, timer_interrupt}, {63'h0, m_irq});
        check_output("model_rdata", {32'h0, rdata}, {32'h0, model_read(addr, rd_en)});
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                  input logic we, input logic re);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr_en = we;
        rd_en = re;
    endtask

    task automatic idle();
        apply_stimulus(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic write_reg(input int off, input logic [31:0] d);
        apply_stimulus(BASE + off, d, 1'b1, 1'b0);
    endtask

    task automatic check_read(input int off, input logic [31:0] exp, input string name);
        apply_stimulus(BASE + off, 32'h0, 1'b0, 1'b1);
        #2;
        check_output(name, {32'h0, rdata}, {32'h0, exp});
    endtask

    task automatic check_irq(input logic exp, input string name);
        check_output(name, {63'h0, timer_interrupt}, {63'h0, exp});
    endtask

    initial begin
        // Reset and reset values.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_read(0,  32'h0,         "rst_mtime_lo");
        check_read(4,  32'h0,         "rst_mtime_hi");
        check_read(8,  32'hFFFF_FFFF, "rst_cmp_lo");
        check_read(12, 32'hFFFF_FFFF, "rst_cmp_hi");
        check_read(16, 32'h0,         "rst_ctrl");
        check_irq(1'b0, "rst_irq");
        repeat (20) idle();
        check_read(0, 32'h0, "idle_mtime_lo");

        // Count every cycle and fire at mtime >= 5.
        write_reg(8, 32'd5);
        write_reg(12, 32'd0);
        write_reg(16, 32'h1);
        for (int k = 0; k < 8; k++) begin
            check_read(0, k, "count_mtime");
            check_irq(k >= 6, "count_irq");
        end
        write_reg(8, 32'd100);
        idle();
        #2 check_irq(1'b1, "irq_before_cmp_raise");
        idle();
        #2 check_irq(1'b0, "irq_after_cmp_raise");

        // PRESC = 3: one tick every 4 cycles.
        write_reg(16, 32'h0);
        write_reg(0, 32'h0);
        write_reg(4, 32'h0);
        write_reg(16, 32'h0000_0301);
        repeat (39) idle();
        check_read(0, 32'd9,  "presc_39");
        check_read(0, 32'd10, "presc_40");
        check_read(16, 32'h0000_0301, "ctrl_readback");

        // 64-bit wrap.
        write_reg(16, 32'h0);
        write_reg(8,  32'hFFFF_FFFF);
        write_reg(12, 32'hFFFF_FFFF);
        write_reg(0,  32'hFFFF_FFFF);
        write_reg(4,  32'hFFFF_FFFF);
        write_reg(16, 32'h1);
        check_read(4, 32'hFFFF_FFFF, "wrap_hi_max");
        check_irq(1'b0, "wrap_irq_pre");
        check_read(4, 32'h0, "wrap_hi_zero");
        check_irq(1'b1, "wrap_irq_at_max");
        check_read(0, 32'h1, "wrap_lo_one");
        check_irq(1'b0, "wrap_irq_after");

        // Software write on a tick edge beats the increment.
        write_reg(0, 32'h10);
        check_read(0, 32'h10, "write_beats_tick");
        check_read(0, 32'h11, "tick_after_write");
        check_read(4, 32'h0,  "write_hi_kept");

        // Out-of-window / misaligned / reserved accesses.
        write_reg(16, 32'h0);
        write_reg(0, 32'h55);
        apply_stimulus(BASE + 32'h02, 32'hDEAD, 1'b1, 1'b1);
        #2 check_output("misaligned_rdata", {32'h0, rdata}, 64'h0);
        apply_stimulus(BASE + 32'h18, 32'hDEAD, 1'b1, 1'b1);
        #2 check_output("reserved_rdata", {32'h0, rdata}, 64'h0);
        apply_stimulus(BASE + 32'h20, 32'hDEAD, 1'b1, 1'b1);
        #2 check_output("outside_rdata", {32'h0, rdata}, 64'h0);
        check_read(0,  32'h55,        "bad_acc_mtime_lo");
        check_read(4,  32'h0,         "bad_acc_mtime_hi");
        check_read(8,  32'hFFFF_FFFF, "bad_acc_cmp_lo");
        check_read(16, 32'h0,         "bad_acc_ctrl");

        // Reset while the interrupt is high, with a write in flight.
        write_reg(8, 32'h0);
        write_reg(12, 32'h0);
        write_reg(16, 32'h1);
        idle();
        idle();
        #2 check_irq(1'b1, "irq_high_before_rst");
        write_reg(0, 32'h77);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        #2 check_irq(1'b0, "irq_after_rst");
        check_read(0,  32'h0,         "mid_rst_mtime_lo");
        check_read(12, 32'hFFFF_FFFF, "mid_rst_cmp_hi");
        check_read(16, 32'h0,         "mid_rst_ctrl");
        idle();
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
